// File: rtl/counter_sched_if.sv
// Requester-side bundle of the counter scheduler: job requests in, grant/done/result back.
interface counter_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] base_in;
    logic [8*NREQ-1:0] len_in;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic [7:0]        result;
    logic              busy;

    modport master (
        output req, base_in, len_in,
        input  grant, done, result, busy
    );

    modport slave (
        input  req, base_in, len_in,
        output grant, done, result, busy
    );
endinterface

// File: rtl/counter_sched.sv
// Round-robin sharing of one 8-bit sync counter: load base, count len cycles, capture, pulse done.
// Latency: req in IDLE at t -> done at t+3+len. Requests simply wait (level req) while a job owns the counter.
module counter_sched #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    counter_sched_if.slave    rq,
    output logic              ctr_rst,
    output logic              ctr_load,
    output logic              ctr_out_en,
    output logic [7:0]        ctr_base,
    input  logic [7:0]        ctr_state
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, CAPTURE} state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   ptr_q, win_q, pick;
    logic              found;
    logic [NREQ-1:0]   eligible, win_oh, done_q;
    logic [7:0]        len_q, base_q, result_q;
    int                j;

    // Requesters that see their own done this cycle are masked so they cannot win again immediately.
    always_comb begin
        eligible = rq.req & ~done_q;
        pick     = '0;
        found    = 1'b0;
        j        = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr_q) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!found && eligible[j]) begin
                found = 1'b1;
                pick  = IDXW'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (found) state_d = LOAD;
            LOAD:    state_d = (len_q != 8'd0) ? RUN : CAPTURE;
            RUN:     if (len_q == 8'd1) state_d = CAPTURE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        win_oh        = '0;
        win_oh[win_q] = 1'b1;
    end

    assign rq.grant   = (state_q != IDLE) ? win_oh : '0;
    assign rq.busy    = (state_q != IDLE);
    assign rq.done    = done_q;
    assign rq.result  = result_q;
    assign ctr_rst    = ~rst_n;
    assign ctr_load   = (state_q == LOAD);
    assign ctr_out_en = (state_q == CAPTURE);
    assign ctr_base   = base_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            done_q   <= '0;
            len_q    <= '0;
            base_q   <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (found) begin
                        win_q  <= pick;
                        base_q <= rq.base_in[8*pick +: 8];
                        len_q  <= rq.len_in[8*pick +: 8];
                    end
                end
                RUN: len_q <= len_q - 8'd1;
                CAPTURE: begin
                    // ctr_state is only driven while out_en is high, i.e. in this state.
                    result_q <= ctr_state;
                    done_q   <= win_oh;
                    ptr_q    <= (win_q == IDXW'(NREQ - 1)) ? '0 : win_q + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: directed scenarios plus random traffic against a job-timeline reference model.
module tb_counter_sched;
    localparam int NREQ = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ctr_rst, ctr_load, ctr_out_en;
    logic [7:0] ctr_base, ctr_state, cnt;

    always #5 clk = ~clk;

    counter_sched_if #(.NREQ(NREQ)) rq_if ();

    counter_sched #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rq         (rq_if),
        .ctr_rst    (ctr_rst),
        .ctr_load   (ctr_load),
        .ctr_out_en (ctr_out_en),
        .ctr_base   (ctr_base),
        .ctr_state  (ctr_state)
    );

    // Stand-in for the shared counter; garbage is driven whenever its output is not enabled.
    always @(posedge clk) begin
        if (ctr_rst)       cnt <= 8'd0;
        else if (ctr_load) cnt <= ctr_base;
        else               cnt <= cnt + 8'd1;
    end
    assign ctr_state = ctr_out_en ? cnt : (cnt ^ 8'hA5);

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: each job is a scheduled window [load_c, cap_c] with done at cap_c+1.
    bit              job_act = 0;
    int              load_c = 0, cap_c = 0, owner = 0, ptr_m = 0;
    logic [7:0]      res_m = 8'd0, base_m = 8'd0, job_res = 8'd0;
    logic [NREQ-1:0] done_e;
    bit              in_job_e;

    logic [NREQ-1:0] s_grant, s_done;
    logic            s_load, s_busy, s_rst;
    logic [7:0]      s_res;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs != exp) begin
            errors++;
            if (errors < 40) $display("FAIL %s got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        logic [NREQ-1:0] g_e, elig;
        int idx, len;
        bit picked;
        @(negedge clk);
        in_job_e = job_act && cyc >= load_c && cyc <= cap_c;
        g_e      = in_job_e ? NREQ'(1) << owner : '0;
        done_e   = (job_act && cyc == cap_c + 1) ? NREQ'(1) << owner : '0;
        if (job_act && cyc == cap_c + 1) res_m = job_res;
        chk("grant",      rq_if.grant,  g_e);
        chk("done",       rq_if.done,   done_e);
        chk("result",     rq_if.result, res_m);
        chk("busy",       rq_if.busy,   in_job_e);
        chk("ctr_load",   ctr_load,     job_act && cyc == load_c);
        chk("ctr_out_en", ctr_out_en,   job_act && cyc == cap_c);
        chk("ctr_rst",    ctr_rst,      !rst_n);
        chk("ctr_base",   ctr_base,     base_m);
        s_grant = rq_if.grant; s_done = rq_if.done; s_res = rq_if.result;
        s_load  = ctr_load;    s_busy = rq_if.busy; s_rst = ctr_rst;
        if (!rst_n) begin
            job_act = 0; res_m = 8'd0; ptr_m = 0; base_m = 8'd0;
        end else if (!job_act || cyc > cap_c) begin
            elig   = rq_if.req & ~done_e;
            picked = 0;
            for (int k = 0; k < NREQ; k++) begin
                idx = (ptr_m + k) % NREQ;
                if (!picked && elig[idx]) begin
                    picked  = 1;
                    owner   = idx;
                    base_m  = rq_if.base_in[8*idx +: 8];
                    len     = int'(rq_if.len_in[8*idx +: 8]);
                    load_c  = cyc + 1;
                    cap_c   = cyc + 2 + len;
                    job_res = 8'((int'(base_m) + len) % 256);
                    ptr_m   = (idx + 1) % NREQ;
                    job_act = 1;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [7:0] b, input logic [7:0] l);
        rq_if.req[i]            = v;
        rq_if.base_in[8*i +: 8] = b;
        rq_if.len_in[8*i +: 8]  = l;
    endtask

    task automatic run_job(input int i, input logic [7:0] b, input logic [7:0] l,
                           input logic [7:0] exp_res, input string tag);
        int gcnt = 0;
        int lat  = -1;
        set_req(i, 1'b1, b, l);
        for (int n = 0; n < 300 && lat < 0; n++) begin
            step();
            if (s_grant[i]) gcnt++;
            if (s_done[i])  lat = n;
        end
        rq_if.req[i] = 1'b0;
        chk({tag, "_grant_cycles"}, gcnt, int'(l) + 2);
        chk({tag, "_done_latency"}, lat,  int'(l) + 3);
        chk({tag, "_result"},       s_res, exp_res);
        step();
        chk({tag, "_busy_after"},   s_busy, 0);
    endtask

    initial begin
        int gap, dcnt, nload, first_load;
        int order[5];
        rst_n         = 1'b0;
        rq_if.req     = '0;
        rq_if.base_in = '0;
        rq_if.len_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        step();
        chk("reset_grant", s_grant, 0);
        chk("reset_result", s_res, 0);
        chk("reset_ctr_rst", s_rst, 1);
        rst_n = 1'b1;
        repeat (2) step();

        run_job(0, 8'h10, 8'd5, 8'h15, "single");
        run_job(1, 8'hFE, 8'd3, 8'h01, "wrap");
        run_job(3, 8'h42, 8'd0, 8'h42, "zero");

        // Requester 2 holds req through its own done: next LOAD must come two cycles after done.
        set_req(2, 1'b1, 8'h20, 8'd2);
        dcnt = -1;
        for (int n = 0; n < 50 && dcnt < 0; n++) begin step(); if (s_done[2]) dcnt = n; end
        gap = -1;
        for (int n = 1; n < 50 && gap < 0; n++) begin step(); if (s_load && s_grant[2]) gap = n; end
        chk("mask_regrant_gap", gap, 2);
        rq_if.req[2] = 1'b0;
        dcnt = 0;
        for (int n = 0; n < 50 && dcnt == 0; n++) begin step(); if (s_done[2]) dcnt = 1; end
        chk("drop_after_grant_done", dcnt, 1);
        step();

        // Pointer moves to 2, then a job for requester 2 is aborted by reset mid-RUN.
        run_job(1, 8'h05, 8'd1, 8'h06, "pre_reset");
        set_req(2, 1'b1, 8'h30, 8'd10);
        repeat (4) step();
        rst_n = 1'b0;
        step();
        chk("midrst_ctr_rst", s_rst, 1);
        rst_n = 1'b1;
        rq_if.req[2] = 1'b0;
        step();
        chk("midrst_grant", s_grant, 0);
        chk("midrst_busy", s_busy, 0);
        chk("midrst_result", s_res, 0);
        dcnt = 0;
        for (int n = 0; n < 20; n++) begin step(); if (s_done != 0) dcnt++; end
        chk("midrst_no_done", dcnt, 0);

        // All four requesting, len=1: grants must rotate 0,1,2,3,0 starting from the reset pointer.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 8'(8'h40 + i), 8'd1);
        nload = 0;
        for (int n = 0; n < 100 && nload < 5; n++) begin
            step();
            if (s_load) begin
                first_load = -1;
                for (int i = 0; i < NREQ; i++) if (s_grant[i]) first_load = i;
                order[nload] = first_load;
                nload++;
            end
        end
        chk("rr_count", nload, 5);
        for (int k = 0; k < 5; k++) chk($sformatf("rr_order%0d", k), order[k], k % NREQ);
        rq_if.req = '0;
        repeat (6) step();

        // Random traffic: requesters raise jobs, hold until done, occasionally drop while granted.
        for (int n = 0; n < 4000; n++) begin
            rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (done_e[i]) begin
                    if ($urandom_range(0, 1) == 0) rq_if.req[i] = 1'b0;
                end else if (!rq_if.req[i]) begin
                    if ($urandom_range(0, 3) == 0)
                        set_req(i, 1'b1, 8'($urandom_range(0, 255)),
                                ($urandom_range(0, 49) == 0) ? 8'($urandom_range(240, 255))
                                                             : 8'($urandom_range(0, 12)));
                end else if (in_job_e && owner == i && $urandom_range(0, 15) == 0) begin
                    rq_if.req[i] = 1'b0;
                end
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
